// File: rtl/phy_mem_bridge_if.sv
// rtl/phy_mem_bridge_if.sv - MMU physical-port and DRAM command/read signal bundle
interface phy_mem_bridge_if;
  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [511:0] data;
    logic [31:0]  addr;
  } mem_req_t;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } mem_resp_t;

  mem_req_t     phy_mem_reqs;
  logic         phy_mem_req_grants;
  mem_resp_t    phy_mem_resps;
  logic         phy_mem_resp_grants;

  logic         dram_cmd_valid;
  logic         dram_cmd_ready;
  logic         dram_cmd_isWrite;
  logic [31:0]  dram_cmd_addr;
  logic [511:0] dram_cmd_data;
  logic         dram_rd_valid;
  logic [511:0] dram_rd_data;

  modport slave (
    input  phy_mem_reqs,
    output phy_mem_req_grants,
    output phy_mem_resps,
    input  phy_mem_resp_grants,
    output dram_cmd_valid,
    input  dram_cmd_ready,
    output dram_cmd_isWrite,
    output dram_cmd_addr,
    output dram_cmd_data,
    input  dram_rd_valid,
    input  dram_rd_data
  );

  modport master (
    output phy_mem_reqs,
    input  phy_mem_req_grants,
    input  phy_mem_resps,
    output phy_mem_resp_grants,
    input  dram_cmd_valid,
    output dram_cmd_ready,
    input  dram_cmd_isWrite,
    input  dram_cmd_addr,
    input  dram_cmd_data,
    output dram_rd_valid,
    output dram_rd_data
  );
endinterface

// File: rtl/phy_mem_bridge.sv
// rtl/phy_mem_bridge.sv - MMU physical-port to DRAM bridge with request FIFO, read credits and response FIFO
module phy_mem_bridge #(
  parameter int REQ_DEPTH  = 4,
  parameter int RESP_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  phy_mem_bridge_if.slave                  bus,
  output logic [$clog2(RESP_DEPTH+1)-1:0]  rd_outstanding,
  output logic                             err_unexpected_rd
);
  localparam int RA = $clog2(REQ_DEPTH);
  localparam int RC = $clog2(REQ_DEPTH + 1);
  localparam int SA = $clog2(RESP_DEPTH);
  localparam int SC = $clog2(RESP_DEPTH + 1);
  localparam logic [RC:0] REQ_LIM  = (RC+1)'(REQ_DEPTH);
  localparam logic [SC:0] RESP_LIM = (SC+1)'(RESP_DEPTH);

  logic          req_is_write [REQ_DEPTH];
  logic [31:0]   req_addr     [REQ_DEPTH];
  logic [511:0]  req_data     [REQ_DEPTH];
  logic [RA-1:0] req_wr_ptr;
  logic [RA-1:0] req_rd_ptr;
  logic [RC-1:0] req_count;
  logic          req_grant;
  logic          req_push;
  logic          req_pop;
  logic          req_empty;

  logic [511:0]  resp_mem [RESP_DEPTH];
  logic [SA-1:0] resp_wr_ptr;
  logic [SA-1:0] resp_rd_ptr;
  logic [SC-1:0] resp_count;
  logic          resp_push;
  logic          resp_pop;
  logic          resp_valid;

  logic          credit_ok;
  logic          cmd_valid;
  logic          rd_issue;

  assign req_push  = req_grant && bus.phy_mem_reqs.valid;
  assign req_empty = (req_count == '0);
  // Reads only go out when a response slot is guaranteed, so the response FIFO never overflows.
  assign credit_ok = ({1'b0, rd_outstanding} + {1'b0, resp_count}) < RESP_LIM;
  assign cmd_valid = !req_empty && (req_is_write[req_rd_ptr] || credit_ok);
  assign req_pop   = cmd_valid && bus.dram_cmd_ready;
  assign rd_issue  = req_pop && !req_is_write[req_rd_ptr];

  assign resp_push  = bus.dram_rd_valid && (rd_outstanding != '0);
  assign resp_valid = (resp_count != '0);
  assign resp_pop   = resp_valid && bus.phy_mem_resp_grants;

  assign bus.phy_mem_req_grants = req_grant;
  assign bus.dram_cmd_valid     = cmd_valid;
  assign bus.dram_cmd_isWrite   = req_is_write[req_rd_ptr];
  assign bus.dram_cmd_addr      = req_addr[req_rd_ptr];
  assign bus.dram_cmd_data      = req_data[req_rd_ptr];
  assign bus.phy_mem_resps      = {resp_valid, resp_valid ? resp_mem[resp_rd_ptr] : 512'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      req_grant <= 1'b0;
    end else begin
      req_grant <= bus.phy_mem_reqs.valid && !req_grant &&
                   (({1'b0, req_count} + {{RC{1'b0}}, req_grant}) < REQ_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (req_push) begin
      req_is_write[req_wr_ptr] <= bus.phy_mem_reqs.isWrite;
      req_addr[req_wr_ptr]     <= bus.phy_mem_reqs.addr;
      req_data[req_wr_ptr]     <= bus.phy_mem_reqs.data;
    end
    if (resp_push) begin
      resp_mem[resp_wr_ptr] <= bus.dram_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_count  <= '0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + RA'(1);
      if (req_pop)  req_rd_ptr <= req_rd_ptr + RA'(1);
      case ({req_push, req_pop})
        2'b10:   req_count <= req_count + RC'(1);
        2'b01:   req_count <= req_count - RC'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_wr_ptr <= '0;
      resp_rd_ptr <= '0;
      resp_count  <= '0;
    end else begin
      if (resp_push) resp_wr_ptr <= resp_wr_ptr + SA'(1);
      if (resp_pop)  resp_rd_ptr <= resp_rd_ptr + SA'(1);
      case ({resp_push, resp_pop})
        2'b10:   resp_count <= resp_count + SC'(1);
        2'b01:   resp_count <= resp_count - SC'(1);
        default: ;
      endcase
    end
  end

  // A beat arriving with nothing outstanding is dropped rather than underflowing the credit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_outstanding    <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      case ({rd_issue, resp_push})
        2'b10:   rd_outstanding <= rd_outstanding + SC'(1);
        2'b01:   rd_outstanding <= rd_outstanding - SC'(1);
        default: ;
      endcase
      if (bus.dram_rd_valid && (rd_outstanding == '0)) err_unexpected_rd <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phy_mem_bridge.sv
// tb/tb_phy_mem_bridge.sv - scoreboard bench for phy_mem_bridge
module tb_phy_mem_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rd_outstanding;
  logic       err_unexpected_rd;
  int         n_pass = 0;
  int         n_total = 0;
  bit         bp_done;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [511:0] d;
  } cmd_t;

  cmd_t         exp_cmd[$];
  logic [511:0] exp_resp[$];

  phy_mem_bridge_if bus ();

  phy_mem_bridge #(.REQ_DEPTH(4), .RESP_DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .rd_outstanding    (rd_outstanding),
    .err_unexpected_rd (err_unexpected_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compares every accepted command and every consumed response.
  always @(negedge clk) begin
    cmd_t         e;
    logic [511:0] r;
    if (!rst && bus.dram_cmd_valid && bus.dram_cmd_ready) begin
      if (exp_cmd.size() == 0) begin
        n_total++;
        $display("FAIL cmd_unexpected: got command addr %0h, expected none", bus.dram_cmd_addr);
      end else begin
        e = exp_cmd.pop_front();
        chk("cmd_is_write", 32'(bus.dram_cmd_isWrite), 32'(e.w));
        chk("cmd_addr", bus.dram_cmd_addr, e.a);
        chk_wide("cmd_data", bus.dram_cmd_data, e.d);
      end
    end
    if (!rst && bus.phy_mem_resps.valid && bus.phy_mem_resp_grants) begin
      if (exp_resp.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got response %0h, expected none", bus.phy_mem_resps.data);
      end else begin
        r = exp_resp.pop_front();
        chk_wide("resp_data", bus.phy_mem_resps.data, r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [31:0] a, input logic [511:0] d);
    cmd_t c;
    int   t;
    c.w = w;
    c.a = a;
    c.d = d;
    exp_cmd.push_back(c);
    bus.phy_mem_reqs = {1'b1, w, d, a};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.phy_mem_req_grants && t < 300);
    if (!bus.phy_mem_req_grants) begin
      n_total++;
      $display("FAIL req_grant_timeout addr %0h: got no grant, expected one", a);
    end
    tick();
    bus.phy_mem_reqs.valid = 1'b0;
  endtask

  task automatic wait_outstanding(input logic [3:0] v, input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rd_outstanding != v && t < 100);
    chk(name, 32'(rd_outstanding), 32'(v));
    tick();
  endtask

  task automatic rd_beat(input logic [511:0] d, input bit expect_resp);
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_data  = d;
    if (expect_resp) exp_resp.push_back(d);
    tick();
    bus.dram_rd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int gcnt;
    rst = 1'b1;
    bus.phy_mem_reqs        = '0;
    bus.phy_mem_resp_grants = 1'b1;
    bus.dram_cmd_ready      = 1'b1;
    bus.dram_rd_valid       = 1'b0;
    bus.dram_rd_data        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(bus.phy_mem_req_grants), 32'd0);
    chk("rst_resp_valid", 32'(bus.phy_mem_resps.valid), 32'd0);
    chk_wide("rst_resp_data", bus.phy_mem_resps.data, 512'd0);
    chk("rst_cmd_valid", 32'(bus.dram_cmd_valid), 32'd0);
    chk("rst_outstanding", 32'(rd_outstanding), 32'd0);
    chk("rst_err", 32'(err_unexpected_rd), 32'd0);
    tick();
    rst = 1'b0;

    // Single read: cycle-exact grant, issue and return latency.
    tick();
    exp_cmd.push_back('{1'b0, 32'h898, 512'd0});
    bus.phy_mem_reqs = {1'b1, 1'b0, 512'd0, 32'h898};
    @(negedge clk); chk("sr_grant_n", 32'(bus.phy_mem_req_grants), 32'd0);
    tick();
    @(negedge clk); chk("sr_grant_n1", 32'(bus.phy_mem_req_grants), 32'd1);
    chk("sr_cmd_n1", 32'(bus.dram_cmd_valid), 32'd0);
    tick();
    bus.phy_mem_reqs.valid = 1'b0;
    @(negedge clk); chk("sr_cmd_n2", 32'(bus.dram_cmd_valid), 32'd1);
    chk("sr_grant_n2", 32'(bus.phy_mem_req_grants), 32'd0);
    tick();
    @(negedge clk); chk("sr_outstanding_1", 32'(rd_outstanding), 32'd1);
    repeat (8) tick();
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_data  = 512'h42;
    exp_resp.push_back(512'h42);
    @(negedge clk); chk("sr_resp_m", 32'(bus.phy_mem_resps.valid), 32'd0);
    tick();
    bus.dram_rd_valid = 1'b0;
    @(negedge clk); chk("sr_resp_m1", 32'(bus.phy_mem_resps.valid), 32'd1);
    chk("sr_outstanding_0", 32'(rd_outstanding), 32'd0);
    tick();
    @(negedge clk); chk("sr_resp_m2", 32'(bus.phy_mem_resps.valid), 32'd0);
    tick();

    // Backpressure: five reads queued against a stalled backend.
    bus.dram_cmd_ready = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_req(1'b0, 32'h100 + 32'(i * 4), 512'(i));
        bp_done = 1'b1;
      end
    join_none
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.phy_mem_req_grants) gcnt++;
      if (i == 10) chk("bp_head_addr_mid", bus.dram_cmd_addr, 32'h100);
    end
    chk("bp_grant_count", 32'(gcnt), 32'd4);
    chk("bp_cmd_valid_held", 32'(bus.dram_cmd_valid), 32'd1);
    chk("bp_head_addr_end", bus.dram_cmd_addr, 32'h100);
    tick();
    bus.dram_cmd_ready = 1'b1;
    t = 0;
    while (!bp_done && t < 300) begin
      tick();
      t++;
    end
    chk("bp_fifth_granted", 32'(bp_done), 32'd1);
    wait_outstanding(4'd5, "bp_outstanding5");
    for (int i = 0; i < 5; i++) rd_beat(512'hB0 + 512'(i), 1'b1);
    wait_outstanding(4'd0, "bp_drained");

    // Credit limit: nine reads, no returns.
    bus.phy_mem_resp_grants = 1'b0;
    for (int i = 0; i < 9; i++) send_req(1'b0, 32'h200 + 32'(i * 4), 512'd0);
    repeat (3) tick();
    @(negedge clk); chk("cr_outstanding8", 32'(rd_outstanding), 32'd8);
    chk("cr_stalled", 32'(bus.dram_cmd_valid), 32'd0);
    tick();
    rd_beat(512'hC0, 1'b1);
    @(negedge clk); chk("cr_resp_held", 32'(bus.phy_mem_resps.valid), 32'd1);
    chk("cr_still_stalled", 32'(bus.dram_cmd_valid), 32'd0);
    chk("cr_outstanding7", 32'(rd_outstanding), 32'd7);
    tick();
    bus.phy_mem_resp_grants = 1'b1;
    tick();
    tick();
    @(negedge clk); chk("cr_ninth_issued", 32'(rd_outstanding), 32'd8);
    tick();
    for (int i = 1; i < 9; i++) rd_beat(512'hC0 + 512'(i), 1'b1);
    wait_outstanding(4'd0, "cr_drained");

    // Mixed write then read.
    send_req(1'b1, 32'h00420003, 512'hDEAD_BEEF);
    repeat (2) tick();
    @(negedge clk); chk("mx_write_no_credit", 32'(rd_outstanding), 32'd0);
    chk("mx_write_no_resp", 32'(bus.phy_mem_resps.valid), 32'd0);
    tick();
    send_req(1'b0, 32'h154, 512'd0);
    wait_outstanding(4'd1, "mx_read_credit");
    rd_beat(512'h98, 1'b1);
    tick();
    tick();
    @(negedge clk); chk("mx_single_resp", 32'(exp_resp.size()), 32'd0);
    chk("mx_resp_idle", 32'(bus.phy_mem_resps.valid), 32'd0);
    tick();

    // Issue and return in the same cycle, then an unexpected beat.
    send_req(1'b0, 32'h300, 512'd0);
    wait_outstanding(4'd1, "sim_first_issued");
    exp_cmd.push_back('{1'b0, 32'h304, 512'd0});
    bus.phy_mem_reqs = {1'b1, 1'b0, 512'd0, 32'h304};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.phy_mem_req_grants && t < 20);
    chk("sim_grant", 32'(bus.phy_mem_req_grants), 32'd1);
    tick();
    bus.phy_mem_reqs.valid = 1'b0;
    bus.dram_rd_valid = 1'b1;
    bus.dram_rd_data  = 512'hD0;
    exp_resp.push_back(512'hD0);
    @(negedge clk); chk("sim_issue_cycle", 32'(bus.dram_cmd_valid), 32'd1);
    tick();
    bus.dram_rd_valid = 1'b0;
    @(negedge clk); chk("sim_outstanding_unchanged", 32'(rd_outstanding), 32'd1);
    tick();
    rd_beat(512'hD1, 1'b1);
    @(negedge clk); chk("sim_outstanding_0", 32'(rd_outstanding), 32'd0);
    tick();
    rd_beat(512'hEE, 1'b0);
    @(negedge clk); chk("unx_err_set", 32'(err_unexpected_rd), 32'd1);
    chk("unx_no_resp", 32'(bus.phy_mem_resps.valid), 32'd0);
    chk("unx_no_underflow", 32'(rd_outstanding), 32'd0);
    tick();

    // Reset with reads outstanding and responses queued.
    bus.phy_mem_resp_grants = 1'b0;
    for (int i = 0; i < 5; i++) send_req(1'b0, 32'h400 + 32'(i * 4), 512'd0);
    wait_outstanding(4'd5, "rs_outstanding5");
    rd_beat(512'hF0, 1'b0);
    rd_beat(512'hF1, 1'b0);
    @(negedge clk); chk("rs_pre_outstanding", 32'(rd_outstanding), 32'd3);
    chk("rs_pre_resp_valid", 32'(bus.phy_mem_resps.valid), 32'd1);
    tick();
    rst = 1'b1;
    exp_cmd.delete();
    exp_resp.delete();
    tick();
    rst = 1'b0;
    bus.phy_mem_resp_grants = 1'b1;
    @(negedge clk);
    chk("rs_grant", 32'(bus.phy_mem_req_grants), 32'd0);
    chk("rs_resp_valid", 32'(bus.phy_mem_resps.valid), 32'd0);
    chk_wide("rs_resp_data", bus.phy_mem_resps.data, 512'd0);
    chk("rs_cmd_valid", 32'(bus.dram_cmd_valid), 32'd0);
    chk("rs_outstanding", 32'(rd_outstanding), 32'd0);
    chk("rs_err", 32'(err_unexpected_rd), 32'd0);
    tick();
    rd_beat(512'hAB, 1'b0);
    @(negedge clk); chk("rs_stale_err", 32'(err_unexpected_rd), 32'd1);
    chk("rs_stale_no_resp", 32'(bus.phy_mem_resps.valid), 32'd0);
    tick();

    chk("end_cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    chk("end_resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
